// File: rtl/ysyx_25040109_core_ctrl.sv
// Multi-cycle sequencer for the RV32 core.
// Steps fetch/decode/exec/mem/wb and halts on fault.
module ysyx_25040109_core_ctrl #(
  parameter int TMO_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ifu_done,
  input  logic [6:0]       opcode,
  input  logic             inst_invalid,
  input  logic             is_ebreak,
  input  logic             rf_wen_dec,
  input  logic             exu_multi,
  input  logic             exu_done,
  input  logic             lsu_done,
  output logic             ifu_req,
  output logic             inst_latch,
  output logic             exu_start,
  output logic             lsu_req,
  output logic             lsu_wen,
  output logic             rf_wen,
  output logic             pc_wen,
  output logic             halt,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_STOP
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [TMO_W-1:0] TMO_MAX  = '1;
  localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] F_ILL = 2'b01;
  localparam logic [1:0] F_TMO = 2'b10;
  localparam logic [1:0] F_EBK = 2'b11;

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [1:0]       fault_q, fault_d;

  logic is_mem;
  logic is_store;
  logic waiting;
  logic tmo_hit;

  assign is_store = (opcode == OP_STORE);
  assign is_mem   = (opcode == OP_LOAD) | is_store;
  // The wait that would bring the counter to its limit is the last one.
  assign tmo_hit  = (tmo_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    instret_d = instret_q;
    fault_d   = fault_q;
    waiting   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (ifu_done) begin
          state_d = S_DECODE;
        end else begin
          waiting = 1'b1;
          if (tmo_hit) begin
            state_d = S_STOP;
            fault_d = F_TMO;
          end
        end
      end
      S_DECODE: begin
        if (inst_invalid) begin
          state_d = S_STOP;
          fault_d = F_ILL;
        end else if (is_ebreak) begin
          state_d = S_STOP;
          fault_d = F_EBK;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!exu_multi || exu_done) begin
          state_d = is_mem ? S_MEM : S_WB;
        end else begin
          waiting = 1'b1;
          if (tmo_hit) begin
            state_d = S_STOP;
            fault_d = F_TMO;
          end
        end
      end
      S_MEM: begin
        if (lsu_done) begin
          state_d = S_WB;
        end else begin
          waiting = 1'b1;
          if (tmo_hit) begin
            state_d = S_STOP;
            fault_d = F_TMO;
          end
        end
      end
      S_WB: begin
        instret_d = instret_q + CNT_ONE;
        state_d   = S_FETCH;
      end
      S_STOP: begin
        state_d = S_STOP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    if (state_d != state_q) begin
      tmo_d = '0;
    end else if (waiting && (tmo_q != TMO_MAX)) begin
      tmo_d = tmo_q + TMO_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      tmo_q     <= '0;
      instret_q <= '0;
      fault_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      instret_q <= instret_d;
      fault_q   <= fault_d;
    end
  end

  // Counter is zero only in the first cycle of EXEC.
  assign exu_start  = rst_n & (state_q == S_EXEC) & (tmo_q == '0);
  assign ifu_req    = rst_n & (state_q == S_FETCH);
  assign inst_latch = ifu_req & ifu_done;
  assign lsu_req    = rst_n & (state_q == S_MEM);
  assign lsu_wen    = lsu_req & is_store;
  assign pc_wen     = rst_n & (state_q == S_WB);
  assign rf_wen     = pc_wen & rf_wen_dec;
  assign halt       = rst_n & (state_q == S_STOP);
  assign fault_code = fault_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_ysyx_25040109_core_ctrl.sv
// Directed bench for the core sequencer.
// Second instance uses a 4-bit timeout counter.
module tb_ysyx_25040109_core_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ifu_done;
  logic [6:0]  opcode;
  logic        inst_invalid;
  logic        is_ebreak;
  logic        rf_wen_dec;
  logic        exu_multi;
  logic        exu_done;
  logic        lsu_done;

  logic        ifu_req, inst_latch, exu_start, lsu_req, lsu_wen;
  logic        rf_wen, pc_wen, halt;
  logic [1:0]  fault_code;
  logic [31:0] instret;

  logic        ifu_req4, inst_latch4, exu_start4, lsu_req4, lsu_wen4;
  logic        rf_wen4, pc_wen4, halt4;
  logic [1:0]  fault_code4;
  logic [31:0] instret4;

  int n_assert;
  int n_fail;
  int starts;

  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_MUL   = 7'b0110011;

  ysyx_25040109_core_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ifu_done(ifu_done),
    .opcode(opcode), .inst_invalid(inst_invalid),
    .is_ebreak(is_ebreak), .rf_wen_dec(rf_wen_dec),
    .exu_multi(exu_multi), .exu_done(exu_done),
    .lsu_done(lsu_done), .ifu_req(ifu_req),
    .inst_latch(inst_latch), .exu_start(exu_start),
    .lsu_req(lsu_req), .lsu_wen(lsu_wen),
    .rf_wen(rf_wen), .pc_wen(pc_wen), .halt(halt),
    .fault_code(fault_code), .instret(instret)
  );

  ysyx_25040109_core_ctrl #(.TMO_W(4), .CNT_W(32)) dut4 (
    .clk(clk), .rst_n(rst_n), .ifu_done(ifu_done),
    .opcode(opcode), .inst_invalid(inst_invalid),
    .is_ebreak(is_ebreak), .rf_wen_dec(rf_wen_dec),
    .exu_multi(exu_multi), .exu_done(exu_done),
    .lsu_done(lsu_done), .ifu_req(ifu_req4),
    .inst_latch(inst_latch4), .exu_start(exu_start4),
    .lsu_req(lsu_req4), .lsu_wen(lsu_wen4),
    .rf_wen(rf_wen4), .pc_wen(pc_wen4), .halt(halt4),
    .fault_code(fault_code4), .instret(instret4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // From a FETCH negedge: pulse ifu_done, land in EXEC.
  task automatic fetch_decode;
    ifu_done = 1'b1;
    tick();
    ifu_done = 1'b0;
    tick();
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    starts       = 0;
    rst_n        = 1'b0;
    ifu_done     = 1'b0;
    opcode       = OP_ADDI;
    inst_invalid = 1'b0;
    is_ebreak    = 1'b0;
    rf_wen_dec   = 1'b1;
    exu_multi    = 1'b0;
    exu_done     = 1'b0;
    lsu_done     = 1'b0;

    tick();
    chk("rst_ifu_req", {31'd0, ifu_req}, 32'd0);
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_fault", {30'd0, fault_code}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_pc_wen", {31'd0, pc_wen}, 32'd0);
    rst_n = 1'b1;
    #1;

    // T1 addi, ifu_done in second FETCH cycle
    chk("t1_ifu_req", {31'd0, ifu_req}, 32'd1);
    chk("t1_latch0", {31'd0, inst_latch}, 32'd0);
    tick();
    ifu_done = 1'b1;
    #1;
    chk("t1_latch1", {31'd0, inst_latch}, 32'd1);
    tick();
    ifu_done = 1'b0;
    #1;
    chk("t1_dec_ifu_req", {31'd0, ifu_req}, 32'd0);
    chk("t1_dec_pc_wen", {31'd0, pc_wen}, 32'd0);
    tick();
    chk("t1_exu_start", {31'd0, exu_start}, 32'd1);
    tick();
    chk("t1_wb_pc_wen", {31'd0, pc_wen}, 32'd1);
    chk("t1_wb_rf_wen", {31'd0, rf_wen}, 32'd1);
    chk("t1_wb_instret", instret, 32'd0);
    tick();
    chk("t1_instret", instret, 32'd1);
    chk("t1_refetch", {31'd0, ifu_req}, 32'd1);

    // T2 lw, lsu_done in fifth MEM cycle
    opcode = OP_LOAD;
    fetch_decode();
    tick();
    for (int i = 1; i <= 5; i++) begin
      chk("t2_lsu_req", {31'd0, lsu_req}, 32'd1);
      chk("t2_lsu_wen", {31'd0, lsu_wen}, 32'd0);
      if (i == 5) lsu_done = 1'b1;
      tick();
    end
    lsu_done = 1'b0;
    #1;
    chk("t2_wb_lsu_req", {31'd0, lsu_req}, 32'd0);
    chk("t2_wb_rf_wen", {31'd0, rf_wen}, 32'd1);
    chk("t2_wb_pc_wen", {31'd0, pc_wen}, 32'd1);
    tick();
    chk("t2_instret", instret, 32'd2);

    // Stray done pulses in FETCH are ignored
    lsu_done = 1'b1;
    exu_done = 1'b1;
    tick();
    lsu_done = 1'b0;
    exu_done = 1'b0;
    #1;
    chk("stray_fetch", {31'd0, ifu_req}, 32'd1);

    // T3 sw, no register write
    opcode     = OP_STORE;
    rf_wen_dec = 1'b0;
    fetch_decode();
    tick();
    chk("t3_lsu_req", {31'd0, lsu_req}, 32'd1);
    chk("t3_lsu_wen", {31'd0, lsu_wen}, 32'd1);
    lsu_done = 1'b1;
    tick();
    lsu_done = 1'b0;
    #1;
    chk("t3_rf_wen", {31'd0, rf_wen}, 32'd0);
    chk("t3_pc_wen", {31'd0, pc_wen}, 32'd1);
    tick();
    chk("t3_instret", instret, 32'd3);

    // T4 mul, exu_done in 33rd EXEC cycle
    opcode     = OP_MUL;
    rf_wen_dec = 1'b1;
    exu_multi  = 1'b1;
    fetch_decode();
    for (int i = 1; i <= 33; i++) begin
      if (exu_start) starts++;
      chk("t4_no_wb", {31'd0, pc_wen}, 32'd0);
      if (i == 33) exu_done = 1'b1;
      tick();
    end
    exu_done = 1'b0;
    #1;
    chk("t4_starts", starts, 32'd1);
    chk("t4_wb_pc_wen", {31'd0, pc_wen}, 32'd1);
    chk("t4_wb_rf_wen", {31'd0, rf_wen}, 32'd1);
    tick();
    chk("t4_instret", instret, 32'd4);

    // Multi-cycle done in the start cycle
    fetch_decode();
    chk("t4b_start", {31'd0, exu_start}, 32'd1);
    exu_done = 1'b1;
    tick();
    exu_done  = 1'b0;
    exu_multi = 1'b0;
    #1;
    chk("t4b_wb", {31'd0, pc_wen}, 32'd1);
    tick();
    chk("t4b_instret", instret, 32'd5);

    // T5 illegal has priority over ebreak
    opcode       = OP_ADDI;
    inst_invalid = 1'b1;
    is_ebreak    = 1'b1;
    fetch_decode();
    chk("t5_halt", {31'd0, halt}, 32'd1);
    chk("t5_fault", {30'd0, fault_code}, 32'd1);
    chk("t5_ifu_req", {31'd0, ifu_req}, 32'd0);
    ifu_done = 1'b1;
    #1;
    chk("t5_latch", {31'd0, inst_latch}, 32'd0);
    tick();
    ifu_done = 1'b0;
    #1;
    chk("t5_stay_ifu", {31'd0, ifu_req}, 32'd0);
    chk("t5_stay_halt", {31'd0, halt}, 32'd1);
    chk("t5_instret", instret, 32'd5);

    rst_n = 1'b0;
    #1;
    chk("t5_rst_halt", {31'd0, halt}, 32'd0);
    chk("t5_rst_fault", {30'd0, fault_code}, 32'd0);
    chk("t5_rst_instret", instret, 32'd0);
    tick();
    rst_n        = 1'b1;
    inst_invalid = 1'b0;
    #1;
    fetch_decode();
    chk("t5_ebk_halt", {31'd0, halt}, 32'd1);
    chk("t5_ebk_fault", {30'd0, fault_code}, 32'd3);
    is_ebreak = 1'b0;

    // T6 timeout on the 4-bit instance
    opcode = OP_LOAD;
    do_reset();
    fetch_decode();
    tick();
    for (int i = 1; i <= 15; i++) begin
      chk("t6_mem_req", {31'd0, lsu_req4}, 32'd1);
      tick();
    end
    chk("t6_tmo_halt", {31'd0, halt4}, 32'd1);
    chk("t6_tmo_fault", {30'd0, fault_code4}, 32'd2);
    chk("t6_tmo_lsu_req", {31'd0, lsu_req4}, 32'd0);
    chk("t6_wide_mem", {31'd0, lsu_req}, 32'd1);
    lsu_done = 1'b1;
    tick();
    lsu_done = 1'b0;
    #1;
    chk("t6_wide_wb", {31'd0, pc_wen}, 32'd1);
    chk("t6_stop_sticky", {31'd0, halt4}, 32'd1);

    // Done on the limit cycle wins
    do_reset();
    fetch_decode();
    tick();
    for (int i = 1; i <= 15; i++) begin
      if (i == 15) lsu_done = 1'b1;
      tick();
    end
    lsu_done = 1'b0;
    #1;
    chk("t6_edge_wb", {31'd0, pc_wen4}, 32'd1);
    chk("t6_edge_halt", {31'd0, halt4}, 32'd0);
    chk("t6_edge_fault", {30'd0, fault_code4}, 32'd0);
    tick();
    chk("t6_edge_instret", instret4, 32'd1);

    // Reset in the middle of MEM
    fetch_decode();
    tick();
    tick();
    chk("t6_mid_mem", {31'd0, lsu_req4}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_mid_lsu_req", {31'd0, lsu_req4}, 32'd0);
    chk("t6_mid_instret", instret4, 32'd0);
    chk("t6_mid_ifu_req", {31'd0, ifu_req4}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("t6_mid_fetch", {31'd0, ifu_req4}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
